// File: rtl/inst_fetch_queue.sv
// -----------------------------------------------------------------------------
// inst_fetch_queue
//
// Fetch-side prefetch buffer sitting between the instruction memory port and
// the IF/ID pipeline register. It owns the fetch PC, issues in-order word
// requests to a variable-latency memory, buffers returned instructions with
// their PCs and hands them to IF/ID under a valid/ready handshake. A taken
// branch redirect from ID flushes the buffer and discards in-flight responses.
//
// Parameters:
//   DEPTH      FIFO entries (power of two, >= 2)
//   MAX_OUTST  maximum outstanding memory requests (>= 1)
//   RESET_PC   first fetch address after start
//
// Ports:
//   clk_i          clock
//   rst_i          asynchronous reset, active-high
//   start_i        fetch enable; low holds fetch idle / stops new issues
//   imem_req_o     request strobe, one request per cycle high
//   imem_addr_o    word-aligned request address (0 when no request)
//   imem_rvalid_i  response valid, in order, latency >= 1 cycle
//   imem_rdata_i   response instruction
//   redirect_i     branch taken in ID; flush and refetch
//   redirect_pc_i  redirect target (bits [1:0] ignored)
//   inst_valid_o   head entry valid
//   inst_o         head instruction
//   pc_o           head PC
//   inst_ready_i   IF/ID accepts the head entry this cycle
//
// Optional build macro:
//   INST_FETCH_QUEUE_BYPASS_EN  when defined, a response arriving while the
//   FIFO is empty (and nothing is being dropped) is presented on the outputs
//   in the same cycle and, if accepted, never written into the FIFO.
// -----------------------------------------------------------------------------
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | after reset, no requests until start_i is seen
// FETCH    | issuing requests under the outstanding/credit limits
// FLUSH    | after a redirect, dropping stale responses; no new requests
//
module inst_fetch_queue #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MAX_OUTST = 2,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  input  logic        inst_ready_i
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned OW = $clog2(MAX_OUTST + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [OW-1:0] drop_q, drop_d;

  // instruction FIFO
  logic [31:0]   fifo_inst [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];
  logic [AW-1:0] fifo_rd_q, fifo_rd_d;
  logic [AW-1:0] fifo_wr_q, fifo_wr_d;

  // addresses of issued, not yet answered (and not dropped) requests
  logic [31:0]   pcq_mem [DEPTH];
  logic [AW-1:0] pcq_rd_q, pcq_rd_d;
  logic [AW-1:0] pcq_wr_q, pcq_wr_d;

  logic rsp_acc;
  logic rsp_drop;
  logic rsp_keep;
  logic credit_ok;
  logic issue;
  logic fifo_empty;
  logic bypass;
  logic bypass_take;
  logic pop;
  logic push;

  // A response with nothing outstanding is illegal and simply ignored.
  assign rsp_acc    = imem_rvalid_i && (outst_q != '0);
  assign rsp_drop   = rsp_acc && (drop_q != '0);
  assign rsp_keep   = rsp_acc && (drop_q == '0);
  assign fifo_empty = (count_q == '0);

  // Buffered entries plus in-flight requests never exceed DEPTH, so every
  // response that is kept always has a FIFO slot waiting for it.
  assign credit_ok = (32'(count_q) + 32'(outst_q)) < DEPTH;

  assign issue = (state_q == ST_FETCH) && start_i && !redirect_i &&
                 (32'(outst_q) < MAX_OUTST) && credit_ok;

`ifdef INST_FETCH_QUEUE_BYPASS_EN
  assign bypass = fifo_empty && rsp_keep && !redirect_i;
`else
  assign bypass = 1'b0;
`endif

  assign bypass_take = bypass && inst_ready_i;

  // Redirect cancels any same-cycle pop or push.
  assign pop  = !fifo_empty && inst_ready_i && !redirect_i;
  assign push = rsp_keep && !redirect_i && !bypass_take;

  assign imem_req_o  = issue;
  assign imem_addr_o = issue ? fetch_pc_q : 32'h0;

  always_comb begin
    inst_valid_o = 1'b0;
    inst_o       = 32'h0;
    pc_o         = 32'h0;
    if (!fifo_empty) begin
      inst_valid_o = 1'b1;
      inst_o       = fifo_inst[fifo_rd_q];
      pc_o         = fifo_pc[fifo_rd_q];
    end else if (bypass) begin
      inst_valid_o = 1'b1;
      inst_o       = imem_rdata_i;
      pc_o         = pcq_mem[pcq_rd_q];
    end
  end

  always_comb begin
    outst_d    = outst_q + OW'(issue) - OW'(rsp_acc);
    drop_d     = drop_q;
    count_d    = count_q;
    fetch_pc_d = fetch_pc_q;
    fifo_rd_d  = fifo_rd_q;
    fifo_wr_d  = fifo_wr_q;
    pcq_rd_d   = pcq_rd_q;
    pcq_wr_d   = pcq_wr_q;
    state_d    = state_q;

    if (redirect_i) begin
      // Every request still in flight after this cycle is stale. In FLUSH no
      // requests are issued, so outstanding equals drop and this expression
      // just carries the existing drop count forward.
      drop_d     = outst_q - OW'(rsp_acc);
      count_d    = '0;
      fetch_pc_d = redirect_pc_i & ~32'h3;
      fifo_rd_d  = '0;
      fifo_wr_d  = '0;
      pcq_rd_d   = '0;
      pcq_wr_d   = '0;
      state_d    = (drop_d != '0) ? ST_FLUSH : ST_FETCH;
    end else begin
      if (rsp_drop) begin
        drop_d = drop_q - OW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        pcq_wr_d   = pcq_wr_q + AW'(1);
      end
      if (rsp_keep) begin
        pcq_rd_d = pcq_rd_q + AW'(1);
      end
      if (push) begin
        fifo_wr_d = fifo_wr_q + AW'(1);
      end
      if (pop) begin
        fifo_rd_d = fifo_rd_q + AW'(1);
      end

      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d = ST_FETCH;
          end
        end
        ST_FETCH: begin
          state_d = ST_FETCH;
        end
        ST_FLUSH: begin
          if (drop_d == '0) begin
            state_d = ST_FETCH;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      fifo_rd_q  <= '0;
      fifo_wr_q  <= '0;
      pcq_rd_q   <= '0;
      pcq_wr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_wr_q  <= fifo_wr_d;
      pcq_rd_q   <= pcq_rd_d;
      pcq_wr_q   <= pcq_wr_d;
    end
  end

  // Storage arrays carry no reset; only entries covered by count are read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_inst[fifo_wr_q] <= imem_rdata_i;
      fifo_pc[fifo_wr_q]   <= pcq_mem[pcq_rd_q];
    end
    if (issue) begin
      pcq_mem[pcq_wr_q] <= fetch_pc_q;
    end
  end

`ifndef SYNTHESIS
  a_rsp_without_req: assert property (@(posedge clk_i) disable iff (rst_i)
    !(imem_rvalid_i && (outst_q == '0)))
    else $error("inst_fetch_queue: imem_rvalid_i with no outstanding request");
`endif

endmodule
